// File: rtl/dma_tb_pkg.sv
// +-----------------------------------------------------------------------+
// | dma_tb_pkg : shared types and sizing helpers for the DMA AHB slave.   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package dma_tb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic int bytes_of(input int data_w);
    return data_w / 8;
  endfunction

  // Keeps the RAM index at least one bit wide for a single-word array.
  function automatic int idx_w_of(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dma_ahb_ram_be.sv
// +-----------------------------------------------------------------------+
// | dma_ahb_ram_be : single-port sync RAM, per-byte write, 1-cycle read.  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module dma_ahb_ram_be #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 512,
  parameter int IDX_W  = 9,
  parameter int BYTES  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTES-1:0]  i_we,
  input  logic              i_re,
  input  logic [IDX_W-1:0]  i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < BYTES; b++) begin
      if (i_we[b]) begin
        r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  // Read register holds its value until the next enabled read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rdata <= '0;
    end else if (i_re) begin
      o_rdata <= r_mem[i_addr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/dma_ahb_slave_model.sv
// +-----------------------------------------------------------------------+
// | dma_ahb_slave_model : AHB-side memory model with byte enables,        |
// | programmable wait states and out-of-range error response. Rev 1.0     |
// +-----------------------------------------------------------------------+
`default_nettype none

module dma_ahb_slave_model
  import dma_tb_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 512,
  parameter int WAIT_W = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     ahb_slave_addr,
  input  logic                  ahb_slave_en,
  input  logic [DATA_W/8-1:0]   ahb_slave_wen,
  input  logic [DATA_W-1:0]     ahb_slave_din,
  input  logic [WAIT_W-1:0]     rd_wait,
  input  logic [WAIT_W-1:0]     wr_wait,
  output logic                  ahb_slave_ready,
  output logic [DATA_W-1:0]     ahb_slave_dout,
  output logic                  ahb_slave_resp
);

  localparam int BYTES = bytes_of(DATA_W);
  localparam int IDX_W = idx_w_of(DEPTH);

  state_t            r_state;
  logic [WAIT_W-1:0] r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [BYTES-1:0]  r_wen;
  logic [DATA_W-1:0] r_din;
  logic              r_ready;
  logic              r_resp;

  logic              w_accept;
  logic [WAIT_W-1:0] w_acc_wait;
  logic              w_direct;
  logic              w_from_wait;
  logic              w_commit;
  logic [ADDR_W-1:0] w_c_addr;
  logic [BYTES-1:0]  w_c_wen;
  logic [DATA_W-1:0] w_c_din;
  logic              w_in_range;
  logic [BYTES-1:0]  w_ram_we;
  logic              w_ram_re;

  // A zero-wait accept commits on the accept edge itself, so the RAM is fed
  // straight from the bus; otherwise it uses the request latched at accept.
  always_comb begin
    w_accept    = ((r_state == IDLE) || (r_state == RESP)) && ahb_slave_en;
    w_acc_wait  = (ahb_slave_wen == '0) ? rd_wait : wr_wait;
    w_direct    = w_accept && (w_acc_wait == '0);
    w_from_wait = (r_state == WAIT) && (r_cnt == WAIT_W'(1));
    w_commit    = w_direct || w_from_wait;
    w_c_addr    = w_direct ? ahb_slave_addr : r_addr;
    w_c_wen     = w_direct ? ahb_slave_wen  : r_wen;
    w_c_din     = w_direct ? ahb_slave_din  : r_din;
    w_ram_we    = (w_commit && w_in_range && reset_n) ? w_c_wen : '0;
    w_ram_re    = w_commit && w_in_range && reset_n && (w_c_wen == '0);
  end

  generate
    if (64'(DEPTH) >= (64'd1 << ADDR_W)) begin : g_full_range
      assign w_in_range = 1'b1;
    end else begin : g_part_range
      assign w_in_range = (w_c_addr < ADDR_W'(DEPTH));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wen   <= '0;
      r_din   <= '0;
      r_ready <= 1'b0;
      r_resp  <= 1'b0;
    end else begin
      r_ready <= w_commit;
      r_resp  <= w_commit && !w_in_range;
      case (r_state)
        IDLE, RESP: begin
          if (ahb_slave_en) begin
            r_addr <= ahb_slave_addr;
            r_wen  <= ahb_slave_wen;
            r_din  <= ahb_slave_din;
            if (w_acc_wait != '0) begin
              r_state <= WAIT;
              r_cnt   <= w_acc_wait;
            end else begin
              r_state <= RESP;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        WAIT: begin
          if (r_cnt == WAIT_W'(1)) begin
            r_state <= RESP;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - WAIT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  dma_ahb_ram_be #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W),
    .BYTES  (BYTES)
  ) u_ram (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_addr  (w_c_addr[IDX_W-1:0]),
    .i_wdata (w_c_din),
    .o_rdata (ahb_slave_dout)
  );

  assign ahb_slave_ready = r_ready;
  assign ahb_slave_resp  = r_resp;

endmodule

`default_nettype wire
